sccb_cfg_sequencer: RTL and testbench

//  Table-driven SCCB register configuration sequencer for OV-series cameras.

---
 rtl/sccb_cfg_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_sccb_cfg_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_cfg_sequencer.sv
// Table-driven SCCB register configuration sequencer: walks a command ROM and issues writes and delays.
// Optional readback verification with retries is enabled by defining SCCB_CFG_VERIFY_EN.
module sccb_cfg_sequencer #(
  parameter logic [7:0] CHIP_ADDR  = 8'h42,
  parameter int         NUM_CMDS   = 64,
  parameter int         IDX_W      = 6,
  parameter int         DELAY_UNIT = 1000,
  parameter int         MAX_RETRY  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_idx,
  output logic [IDX_W-1:0] rom_addr,
  input  logic [15:0]      rom_data,
  output logic             tr_start,
  output logic             tr_rw,
  output logic [7:0]       tr_addr,
  output logic [7:0]       tr_subaddr,
  output logic [7:0]       tr_wdata,
  input  logic [7:0]       tr_rdata,
  input  logic             tr_end
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, ISSUE, WAIT_TR, DELAY, RD_ISSUE, RD_WAIT, DONE, ERROR
  } state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] rom_addr_q, rom_addr_d;
  logic             tr_rw_q, tr_rw_d;
  logic [7:0]       tr_addr_q, tr_addr_d;
  logic [7:0]       tr_subaddr_q, tr_subaddr_d;
  logic [7:0]       tr_wdata_q, tr_wdata_d;
  logic [31:0]      dly_q, dly_d;
  logic [31:0]      dly_prod;
  logic             last_entry;
  logic             advance;

  assign dly_prod   = 32'(rom_data[7:0]) * 32'(DELAY_UNIT);
  assign last_entry = (rom_addr_q == IDX_W'(NUM_CMDS - 1));

`ifdef SCCB_CFG_VERIFY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               error_q, error_d;
  logic [IDX_W-1:0]   err_idx_q, err_idx_d;
  logic               soft_rst;

  // A soft-reset write cannot be read back meaningfully.
  assign soft_rst = (tr_subaddr_q == 8'h12) && tr_wdata_q[7];
`endif

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = done_q;
    rom_addr_d   = rom_addr_q;
    tr_rw_d      = tr_rw_q;
    tr_addr_d    = tr_addr_q;
    tr_subaddr_d = tr_subaddr_q;
    tr_wdata_d   = tr_wdata_q;
    dly_d        = dly_q;
    advance      = 1'b0;
`ifdef SCCB_CFG_VERIFY_EN
    retry_d      = retry_q;
    error_d      = error_q;
    err_idx_d    = err_idx_q;
`endif

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          rom_addr_d = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
`ifdef SCCB_CFG_VERIFY_EN
          error_d    = 1'b0;
`endif
          state_d    = FETCH;
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        if (rom_data == 16'hFFFF) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (rom_data[15:8] == 8'hF0) begin
          // Counter loaded with N-1 so DELAY occupies exactly N cycles.
          if (dly_prod == 32'd0) begin
            advance = 1'b1;
          end else begin
            dly_d   = dly_prod - 32'd1;
            state_d = DELAY;
          end
        end else begin
          tr_subaddr_d = rom_data[15:8];
          tr_wdata_d   = rom_data[7:0];
          tr_rw_d      = 1'b0;
          tr_addr_d    = CHIP_ADDR;
`ifdef SCCB_CFG_VERIFY_EN
          retry_d      = '0;
`endif
          state_d      = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_TR;
      WAIT_TR: begin
        if (tr_end) begin
`ifdef SCCB_CFG_VERIFY_EN
          if (soft_rst) begin
            advance = 1'b1;
          end else begin
            tr_rw_d   = 1'b1;
            tr_addr_d = CHIP_ADDR | 8'h01;
            state_d   = RD_ISSUE;
          end
`else
          advance = 1'b1;
`endif
        end
      end
      DELAY: begin
        if (dly_q == 32'd0) advance = 1'b1;
        else                dly_d   = dly_q - 32'd1;
      end
`ifdef SCCB_CFG_VERIFY_EN
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (tr_end) begin
          if (tr_rdata == tr_wdata_q) begin
            advance = 1'b1;
          end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d   = retry_q + 1'b1;
            tr_rw_d   = 1'b0;
            tr_addr_d = CHIP_ADDR;
            state_d   = ISSUE;
          end else begin
            err_idx_d = rom_addr_q;
            error_d   = 1'b1;
            busy_d    = 1'b0;
            state_d   = ERROR;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (last_entry) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end else begin
        rom_addr_d = rom_addr_q + 1'b1;
        state_d    = FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rom_addr_q   <= '0;
      tr_rw_q      <= 1'b0;
      tr_addr_q    <= CHIP_ADDR;
      tr_subaddr_q <= 8'h00;
      tr_wdata_q   <= 8'h00;
      dly_q        <= 32'd0;
`ifdef SCCB_CFG_VERIFY_EN
      retry_q      <= '0;
      error_q      <= 1'b0;
      err_idx_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rom_addr_q   <= rom_addr_d;
      tr_rw_q      <= tr_rw_d;
      tr_addr_q    <= tr_addr_d;
      tr_subaddr_q <= tr_subaddr_d;
      tr_wdata_q   <= tr_wdata_d;
      dly_q        <= dly_d;
`ifdef SCCB_CFG_VERIFY_EN
      retry_q      <= retry_d;
      error_q      <= error_d;
      err_idx_q    <= err_idx_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rom_addr   = rom_addr_q;
  assign tr_start   = (state_q == ISSUE) || (state_q == RD_ISSUE);
  assign tr_rw      = tr_rw_q;
  assign tr_addr    = tr_addr_q;
  assign tr_subaddr = tr_subaddr_q;
  assign tr_wdata   = tr_wdata_q;

`ifdef SCCB_CFG_VERIFY_EN
  assign error   = error_q;
  assign err_idx = err_idx_q;
`else
  // Readback data and retry limit only matter when verification is built in.
  logic unused_ok;
  assign unused_ok = ^{tr_rdata, MAX_RETRY[0]};
  assign error     = 1'b0;
  assign err_idx   = '0;
`endif

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Directed bench for sccb_cfg_sequencer: registered ROM model plus a simple SCCB master responder.
// Readback scenario runs only when SCCB_CFG_VERIFY_EN is defined.
module tb_sccb_cfg_sequencer;
  localparam int NUM_CMDS = 4;
  localparam int IDX_W    = 6;
  localparam int DU       = 10;
`ifdef SCCB_CFG_VERIFY_EN
  localparam int VF = 1;
`else
  localparam int VF = 0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             busy, done, error, tr_start, tr_rw;
  logic [IDX_W-1:0] err_idx, rom_addr;
  logic [15:0]      rom_data = 16'h0000;
  logic [7:0]       tr_addr, tr_subaddr, tr_wdata;
  logic [7:0]       tr_rdata = 8'h00;
  logic             tr_end = 1'b0;

  logic [15:0] rom [NUM_CMDS];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tr_lat = 4;
  logic       bad_en = 1'b0;
  logic [7:0] bad_sub = 8'h00;
  logic [7:0] last_w = 8'h00;
  logic [31:0] log_q[$];
  int          cyc_q[$];
  int   stab_err = 0;
  int   extra_start = 0;
  logic pend = 1'b0;
  int   lat_cnt = 0;
  logic [31:0] cur = 32'd0;
  localparam logic [40:0] RESET_VEC = {5'b00000, 6'd0, 6'd0, 8'h00, 8'h00, 8'h42};

  sccb_cfg_sequencer #(
    .CHIP_ADDR(8'h42), .NUM_CMDS(NUM_CMDS), .IDX_W(IDX_W), .DELAY_UNIT(DU), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
    .err_idx(err_idx), .rom_addr(rom_addr), .rom_data(rom_data), .tr_start(tr_start),
    .tr_rw(tr_rw), .tr_addr(tr_addr), .tr_subaddr(tr_subaddr), .tr_wdata(tr_wdata),
    .tr_rdata(tr_rdata), .tr_end(tr_end)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rom_data <= rom[rom_addr[1:0]];
  end

  // Master responder: logs each request, ends it tr_lat+1 cycles later, watches field stability.
  always @(negedge clk) begin
    tr_end = 1'b0;
    if (!reset) begin
      pend = 1'b0;
    end else if (pend) begin
      if (tr_start) extra_start++;
      if ({7'd0, tr_rw, tr_addr, tr_subaddr, tr_wdata} !== cur) stab_err++;
      if (lat_cnt == 0) begin
        pend     = 1'b0;
        tr_end   = 1'b1;
        tr_rdata = (bad_en && cur[15:8] == bad_sub) ? 8'h00 : last_w;
      end else begin
        lat_cnt--;
      end
    end else if (tr_start) begin
      cur = {7'd0, tr_rw, tr_addr, tr_subaddr, tr_wdata};
      log_q.push_back(cur);
      cyc_q.push_back(cyc);
      pend    = 1'b1;
      lat_cnt = tr_lat;
      if (!tr_rw) last_w = tr_wdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required sequence completion");
    $fatal(1);
  end

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    int n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(done || error)) begin
      errors++;
      $display("FAIL %s_timeout: done=%0b error=%0b after %0d cycles, required done or error", name, done, error, n);
    end
  endtask

  task automatic clear_log();
    log_q.delete();
    cyc_q.delete();
    stab_err = 0;
    extra_start = 0;
  endtask

  task automatic test_reset();
    logic [40:0] obs;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    obs = {busy, done, error, tr_start, tr_rw, rom_addr, err_idx, tr_subaddr, tr_wdata, tr_addr};
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_outputs: got %h required %h", obs, RESET_VEC);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, tr_start} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: busy/done/tr_start got %b required 000", {busy, done, tr_start});
    end
  endtask

  task automatic test_two_writes();
    int s;
    rom = '{16'h1280, 16'h1204, 16'hFFFF, 16'h0000};
    tr_lat = 4;
    clear_log();
    pulse_start(s);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL two_busy: got %0b required 1", busy);
    end
    wait_end("two", 500);
    checks++;
    if (log_q.size() != 2 + VF) begin
      errors++;
      $display("FAIL two_count: got %0d transactions required %0d", log_q.size(), 2 + VF);
    end
    if (log_q.size() >= 2) begin
      checks++;
      if (log_q[0] !== 32'h0042_1280 || log_q[1] !== 32'h0042_1204) begin
        errors++;
        $display("FAIL two_fields: got %h %h required 00421280 00421204", log_q[0], log_q[1]);
      end
      // start sampled at posedge 0; FETCH, DECODE, ISSUE -> request seen 3 counts later
      checks++;
      if (cyc_q[0] - s != 3) begin
        errors++;
        $display("FAIL two_latency: got %0d required 3", cyc_q[0] - s);
      end
    end
    checks++;
    if ({done, busy, rom_addr} !== {1'b1, 1'b0, 6'd2}) begin
      errors++;
      $display("FAIL two_final: done/busy/rom_addr got %b/%b/%0d required 1/0/2", done, busy, rom_addr);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    clear_log();
    pulse_start(s);
    repeat (6) @(negedge clk);
    pulse_start(s);
    wait_end("b2b_a", 500);
    checks++;
    if (log_q.size() != 2 + VF) begin
      errors++;
      $display("FAIL b2b_ignored_start: got %0d transactions required %0d", log_q.size(), 2 + VF);
    end
    pulse_start(s);
    checks++;
    if ({done, busy} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_restart: done/busy got %b required 01", {done, busy});
    end
    wait_end("b2b_b", 500);
    checks++;
    if (log_q.size() != 2 * (2 + VF)) begin
      errors++;
      $display("FAIL b2b_count: got %0d required %0d", log_q.size(), 2 * (2 + VF));
    end
  endtask

  task automatic test_delay();
    int s;
    int g0;
    int g5;
    rom = '{16'hF000, 16'h1100, 16'hFFFF, 16'h0000};
    clear_log();
    pulse_start(s);
    wait_end("delay0", 500);
    g0 = (cyc_q.size() > 0) ? cyc_q[0] - s : -1;
    // zero delay: FETCH, DECODE of delay entry, then FETCH, DECODE, ISSUE of the write
    checks++;
    if (g0 != 5) begin
      errors++;
      $display("FAIL delay_zero: got gap %0d required 5", g0);
    end
    rom = '{16'hF005, 16'h1100, 16'hFFFF, 16'h0000};
    clear_log();
    pulse_start(s);
    wait_end("delay5", 1000);
    g5 = (cyc_q.size() > 0) ? cyc_q[0] - s : -1;
    checks++;
    if (g5 != 55) begin
      errors++;
      $display("FAIL delay_five: got gap %0d required 55 (5 + 5*10)", g5);
    end
    checks++;
    if (log_q.size() == 0 || log_q[0] !== 32'h0042_1100) begin
      errors++;
      $display("FAIL delay_write: got %0d entries first %h required 00421100", log_q.size(),
               (log_q.size() > 0) ? log_q[0] : 32'hX);
    end
  endtask

  task automatic test_no_marker();
    int s;
    rom = '{16'h1101, 16'h1102, 16'h1103, 16'h1104};
    clear_log();
    pulse_start(s);
    wait_end("nomark", 1000);
    repeat (5) @(negedge clk);
    checks++;
    if (log_q.size() != 4 * (1 + VF)) begin
      errors++;
      $display("FAIL nomark_count: got %0d required %0d", log_q.size(), 4 * (1 + VF));
    end
    checks++;
    if ({done, busy, rom_addr} !== {1'b1, 1'b0, 6'd3}) begin
      errors++;
      $display("FAIL nomark_final: done/busy/rom_addr got %b/%b/%0d required 1/0/3", done, busy, rom_addr);
    end
    checks++;
    if (log_q.size() < 4 || log_q[log_q.size() - 1 - VF] !== 32'h0042_1104) begin
      errors++;
      $display("FAIL nomark_last_write: last write mismatch, required 00421104");
    end
  endtask

  task automatic test_slow_master();
    int s;
    rom = '{16'h1280, 16'hFFFF, 16'h0000, 16'h0000};
    tr_lat = 200;
    clear_log();
    pulse_start(s);
    wait_end("slow", 1000);
    checks++;
    if (stab_err != 0 || extra_start != 0) begin
      errors++;
      $display("FAIL slow_stable: field changes %0d extra starts %0d required 0 0", stab_err, extra_start);
    end
    checks++;
    if (log_q.size() != 1) begin
      errors++;
      $display("FAIL slow_count: got %0d required 1", log_q.size());
    end
    tr_lat = 4;
  endtask

  task automatic test_reset_mid();
    int s;
    logic [40:0] obs;
    rom = '{16'h1280, 16'h1204, 16'hFFFF, 16'h0000};
    tr_lat = 50;
    clear_log();
    pulse_start(s);
    repeat (10) @(negedge clk);
    checks++;
    if (log_q.size() != 1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_in_wait: got %0d transactions busy %0b required 1 1", log_q.size(), busy);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    obs = {busy, done, error, tr_start, tr_rw, rom_addr, err_idx, tr_subaddr, tr_wdata, tr_addr};
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL rmid_reset_outputs: got %h required %h", obs, RESET_VEC);
    end
    reset = 1'b1;
    tr_lat = 4;
    repeat (2) @(negedge clk);
    clear_log();
    pulse_start(s);
    wait_end("rmid", 500);
    checks++;
    if (log_q.size() != 2 + VF || log_q[0] !== 32'h0042_1280) begin
      errors++;
      $display("FAIL rmid_restart: got %0d transactions first %h required %0d 00421280",
               log_q.size(), (log_q.size() > 0) ? log_q[0] : 32'hX, 2 + VF);
    end
  endtask

`ifdef SCCB_CFG_VERIFY_EN
  task automatic test_verify();
    int s;
    rom = '{16'h1101, 16'h1102, 16'h1355, 16'hFFFF};
    bad_en = 1'b1;
    bad_sub = 8'h13;
    clear_log();
    pulse_start(s);
    wait_end("verify", 2000);
    // entries 0,1: one write/read pair each; entry 2: 1 + 3 retries pairs
    checks++;
    if (log_q.size() != 12) begin
      errors++;
      $display("FAIL verify_count: got %0d required 12", log_q.size());
    end
    checks++;
    if ({error, done, busy, err_idx} !== {1'b1, 1'b0, 1'b0, 6'd2}) begin
      errors++;
      $display("FAIL verify_error: error/done/busy/err_idx got %b/%b/%b/%0d required 1/0/0/2",
               error, done, busy, err_idx);
    end
    checks++;
    if (log_q.size() < 6 || log_q[4] !== 32'h0042_1355 || log_q[5] !== 32'h0143_1355) begin
      errors++;
      $display("FAIL verify_pair: entry-2 write/read pair wrong, required 00421355 01431355");
    end
    bad_en = 1'b0;
  endtask
`endif

  initial begin
    rom = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    test_reset();
    test_two_writes();
    test_back_to_back();
    test_delay();
    test_no_marker();
    test_slow_master();
    test_reset_mid();
`ifdef SCCB_CFG_VERIFY_EN
    test_verify();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
